// File: rtl/regfile_pkg.sv
// Shared widths, constants and arbiter state encoding for the register-file
// writeback scheduler.
package regfile_pkg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREGS = 2 ** AW;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the state names the source favoured on
// contention and only moves after a contended grant.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  arb_state_t r_state;
  arb_state_t w_nextState;

  // Favoured-source register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= PRI0;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Grants are forced low for as long as reset is held.
  always_comb begin
    w_nextState = r_state;
    gnt         = 2'b00;
    if (!reset) begin
      if (req == 2'b11) begin
        if (r_state == PRI0) begin
          gnt         = 2'b01;
          w_nextState = PRI1;
        end else begin
          gnt         = 2'b10;
          w_nextState = PRI0;
        end
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between the ALU and load writeback
// sources and tracks a per-register pending-write scoreboard.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          src0_valid,
  input  logic [AW-1:0] src0_reg,
  input  logic [DW-1:0] src0_data,
  output logic          src0_ready,
  input  logic          src1_valid,
  input  logic [AW-1:0] src1_reg,
  input  logic [DW-1:0] src1_data,
  output logic          src1_ready,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_reg,
  input  logic [AW-1:0] query_reg1,
  input  logic [AW-1:0] query_reg2,
  output logic          busy1,
  output logic          busy2,
  output logic          stall,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] writeData,
  output logic          regWrite,
  output logic          waw_error
);

  logic [1:0]       w_gnt;
  logic             w_wrValid;
  logic [AW-1:0]    w_wrReg;
  logic [DW-1:0]    w_wrData;
  logic             w_wrLive;
  logic             w_issueLive;
  logic [NREGS-1:0] w_busyNext;

  logic [AW-1:0]    r_writeReg;
  logic [DW-1:0]    r_writeData;
  logic             r_regWrite;
  logic [NREGS-1:0] r_busy;
  logic             r_waw;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({src1_valid, src0_valid}),
    .gnt   (w_gnt)
  );

  assign src0_ready  = w_gnt[0];
  assign src1_ready  = w_gnt[1];
  assign w_wrValid   = |w_gnt;
  assign w_wrReg     = w_gnt[1] ? src1_reg  : src0_reg;
  assign w_wrData    = w_gnt[1] ? src1_data : src0_data;
  assign w_wrLive    = w_wrValid && (w_wrReg != REG_ZERO);
  assign w_issueLive = issue_valid && (issue_reg != REG_ZERO);

  // Issue is applied after the writeback clear so a same-edge set wins.
  always_comb begin
    w_busyNext = r_busy;
    if (w_wrLive) begin
      w_busyNext[w_wrReg] = 1'b0;
    end
    if (w_issueLive) begin
      w_busyNext[issue_reg] = 1'b1;
    end
  end

  // Register-zero writes are accepted but leave the write port idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_writeReg  <= '0;
      r_writeData <= '0;
      r_regWrite  <= 1'b0;
      r_busy      <= '0;
      r_waw       <= 1'b0;
    end else begin
      r_regWrite <= w_wrLive;
      if (w_wrLive) begin
        r_writeReg  <= w_wrReg;
        r_writeData <= w_wrData;
      end
      r_busy <= w_busyNext;
      if (w_issueLive && r_busy[issue_reg]) begin
        r_waw <= 1'b1;
      end
    end
  end

  assign busy1     = (query_reg1 != REG_ZERO) && r_busy[query_reg1];
  assign busy2     = (query_reg2 != REG_ZERO) && r_busy[query_reg2];
  assign stall     = busy1 | busy2;
  assign writeReg  = r_writeReg;
  assign writeData = r_writeData;
  assign regWrite  = r_regWrite;
  assign waw_error = r_waw;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run against a behavioural model of writes and the scoreboard.
module tb_regfile_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        src0_valid = 1'b0;
  logic [4:0]  src0_reg = '0;
  logic [31:0] src0_data = '0;
  logic        src0_ready;
  logic        src1_valid = 1'b0;
  logic [4:0]  src1_reg = '0;
  logic [31:0] src1_data = '0;
  logic        src1_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic [4:0]  query_reg1 = '0;
  logic [4:0]  query_reg2 = '0;
  logic        busy1, busy2, stall;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic        waw_error;

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural model: pending-write set, favoured source, last write.
  bit          mBusy [32];
  bit          mWaw;
  int          mFav;
  bit          mRegWrite;
  logic [4:0]  mWReg;
  logic [31:0] mWData;

  regfile_wb_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .src0_valid  (src0_valid),
    .src0_reg    (src0_reg),
    .src0_data   (src0_data),
    .src0_ready  (src0_ready),
    .src1_valid  (src1_valid),
    .src1_reg    (src1_reg),
    .src1_data   (src1_data),
    .src1_ready  (src1_ready),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .query_reg1  (query_reg1),
    .query_reg2  (query_reg2),
    .busy1       (busy1),
    .busy2       (busy2),
    .stall       (stall),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .regWrite    (regWrite),
    .waw_error   (waw_error)
  );

  always #5 clock = ~clock;

  task automatic modelReset();
    foreach (mBusy[i]) mBusy[i] = 1'b0;
    mWaw = 0; mFav = 0; mRegWrite = 0; mWReg = '0; mWData = '0;
  endtask

  // Which source the model expects to win with the currently driven inputs.
  task automatic modelGrant(output bit g0, output bit g1);
    if (src0_valid && src1_valid) begin
      g0 = (mFav == 0);
      g1 = (mFav == 1);
    end else begin
      g0 = src0_valid;
      g1 = src1_valid;
    end
  endtask

  task automatic modelEdge();
    bit g0, g1;
    int wr;
    modelGrant(g0, g1);
    mRegWrite = 0;
    if (issue_valid && issue_reg != 0 && mBusy[issue_reg]) mWaw = 1;
    if (g0 || g1) begin
      wr = g0 ? int'(src0_reg) : int'(src1_reg);
      if (wr != 0) begin
        mRegWrite = 1;
        mWReg     = 5'(wr);
        mWData    = g0 ? src0_data : src1_data;
        mBusy[wr] = 0;
      end
    end
    if (src0_valid && src1_valid) mFav = 1 - mFav;
    if (issue_valid && issue_reg != 0) mBusy[issue_reg] = 1;
  endtask

  task automatic tick();
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic clearInputs();
    src0_valid = 0; src1_valid = 0; issue_valid = 0;
    src0_reg = '0; src1_reg = '0; issue_reg = '0;
    src0_data = '0; src1_data = '0;
    query_reg1 = '0; query_reg2 = '0;
  endtask

  task automatic applyStimulus_reset();
    clearInputs();
    reset = 1;
    modelReset();
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    src0_valid = 1; src1_valid = 1; src0_reg = 5'd3; src1_reg = 5'd4;
    #1;
    nChecks++;
    if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
      nFail++; $display("[TB] FAIL reset_ready: got %b%b want 00", src1_ready, src0_ready);
    end
    applyStimulus_reset();
    #1;
    nChecks++;
    if (regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0 || waw_error !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs: regWrite=%b writeReg=%0d writeData=%h waw=%b want all 0",
               regWrite, writeReg, writeData, waw_error);
    end
    nChecks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || stall !== 1'b0) begin
      nFail++; $display("[TB] FAIL reset_busy: busy1=%b busy2=%b stall=%b want 0", busy1, busy2, stall);
    end
  endtask

  task automatic test_single_write();
    @(negedge clock);
    src0_valid = 1; src0_reg = 5'd5; src0_data = 32'hDEADBEEF;
    #1;
    nChecks++;
    if (src0_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL single_ready: got %b want 1", src0_ready);
    end
    tick();
    nChecks++;
    if (regWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'hDEADBEEF) begin
      nFail++;
      $display("[TB] FAIL single_write: regWrite=%b writeReg=%0d writeData=%h want 1/5/deadbeef",
               regWrite, writeReg, writeData);
    end
    @(negedge clock);
    src0_valid = 0;
    tick();
    nChecks++;
    if (regWrite !== 1'b0) begin
      nFail++; $display("[TB] FAIL single_pulse: regWrite=%b want 0", regWrite);
    end
  endtask

  task automatic test_contention();
    logic [4:0] expReg [3];
    bit         expG0 [3];
    expReg = '{5'd3, 5'd4, 5'd3};
    expG0  = '{1'b1, 1'b0, 1'b1};
    applyStimulus_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      src0_valid = 1; src0_reg = 5'd3; src0_data = 32'h11;
      src1_valid = 1; src1_reg = 5'd4; src1_data = 32'h22;
      #1;
      nChecks++;
      if (src0_ready !== expG0[c] || src1_ready !== !expG0[c]) begin
        nFail++;
        $display("[TB] FAIL contention_grant%0d: ready0=%b ready1=%b want %b/%b",
                 c, src0_ready, src1_ready, expG0[c], !expG0[c]);
      end
      tick();
      nChecks++;
      if (regWrite !== 1'b1 || writeReg !== expReg[c] ||
          writeData !== (expG0[c] ? 32'h11 : 32'h22)) begin
        nFail++;
        $display("[TB] FAIL contention_write%0d: regWrite=%b writeReg=%0d writeData=%h want reg %0d",
                 c, regWrite, writeReg, writeData, expReg[c]);
      end
      if (c == 1) begin
        @(negedge clock);
        clearInputs();
        tick();
      end
    end
    @(negedge clock);
    clearInputs();
  endtask

  task automatic test_scoreboard();
    @(negedge clock);
    issue_valid = 1; issue_reg = 5'd7;
    tick();
    @(negedge clock);
    issue_valid = 0; query_reg1 = 5'd7;
    #1;
    nChecks++;
    if (busy1 !== 1'b1 || stall !== 1'b1) begin
      nFail++; $display("[TB] FAIL sb_set: busy1=%b stall=%b want 1/1", busy1, stall);
    end
    tick();
    @(negedge clock);
    src0_valid = 1; src0_reg = 5'd7; src0_data = 32'h77;
    #1;
    nChecks++;
    if (busy1 !== 1'b1 || src0_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL sb_nobypass: busy1=%b ready0=%b want 1/1", busy1, src0_ready);
    end
    tick();
    @(negedge clock);
    src0_valid = 0;
    #1;
    nChecks++;
    if (busy1 !== 1'b0 || stall !== 1'b0) begin
      nFail++; $display("[TB] FAIL sb_clear: busy1=%b stall=%b want 0/0", busy1, stall);
    end
  endtask

  task automatic test_reg_zero();
    @(negedge clock);
    issue_valid = 1; issue_reg = 5'd8;
    tick();
    @(negedge clock);
    issue_valid = 0;
    src1_valid = 1; src1_reg = 5'd0; src1_data = 32'hFFFFFFFF;
    query_reg1 = 5'd0; query_reg2 = 5'd8;
    #1;
    nChecks++;
    if (src1_ready !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL zero_accept: ready1=%b busy1=%b busy2=%b want 1/0/1", src1_ready, busy1, busy2);
    end
    tick();
    nChecks++;
    if (regWrite !== 1'b0 || writeReg !== 5'd7 || writeData !== 32'h77) begin
      nFail++;
      $display("[TB] FAIL zero_nowrite: regWrite=%b writeReg=%0d writeData=%h want 0/7/00000077",
               regWrite, writeReg, writeData);
    end
    @(negedge clock);
    src1_valid = 0;
    #1;
    nChecks++;
    if (busy2 !== 1'b1 || busy1 !== 1'b0) begin
      nFail++; $display("[TB] FAIL zero_sb: busy1=%b busy2=%b want 0/1", busy1, busy2);
    end
  endtask

  task automatic test_waw();
    @(negedge clock);
    issue_valid = 1; issue_reg = 5'd9;
    tick();
    nChecks++;
    if (waw_error !== 1'b0) begin
      nFail++; $display("[TB] FAIL waw_first: waw=%b want 0", waw_error);
    end
    tick();
    nChecks++;
    if (waw_error !== 1'b1) begin
      nFail++; $display("[TB] FAIL waw_second: waw=%b want 1", waw_error);
    end
    @(negedge clock);
    issue_valid = 0; query_reg1 = 5'd9;
    tick();
    nChecks++;
    if (waw_error !== 1'b1 || busy1 !== 1'b1) begin
      nFail++; $display("[TB] FAIL waw_sticky: waw=%b busy1=%b want 1/1", waw_error, busy1);
    end
    @(negedge clock);
    issue_valid = 1; issue_reg = 5'd9;
    src0_valid = 1; src0_reg = 5'd9; src0_data = 32'h99;
    tick();
    @(negedge clock);
    issue_valid = 0; src0_valid = 0;
    #1;
    nChecks++;
    if (busy1 !== 1'b1 || regWrite !== 1'b1 || writeReg !== 5'd9) begin
      nFail++;
      $display("[TB] FAIL waw_setwins: busy1=%b regWrite=%b writeReg=%0d want 1/1/9", busy1, regWrite, writeReg);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clock);
    issue_valid = 1; issue_reg = 5'd12;
    tick();
    @(negedge clock);
    issue_valid = 0;
    src0_valid = 1; src0_reg = 5'd5; src0_data = 32'h55;
    query_reg1 = 5'd12;
    #1;
    nChecks++;
    if (busy1 !== 1'b1 || src0_ready !== 1'b1 || waw_error !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL midop_pre: busy1=%b ready0=%b waw=%b want 1/1/1", busy1, src0_ready, waw_error);
    end
    #1 reset = 1;
    #1;
    modelReset();
    nChecks++;
    if (src0_ready !== 1'b0 || regWrite !== 1'b0 || busy1 !== 1'b0 || waw_error !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL midop_async: ready0=%b regWrite=%b busy1=%b waw=%b want 0/0/0/0",
               src0_ready, regWrite, busy1, waw_error);
    end
    @(posedge clock);
    #1;
    nChecks++;
    if (src0_ready !== 1'b0 || regWrite !== 1'b0) begin
      nFail++; $display("[TB] FAIL midop_hold: ready0=%b regWrite=%b want 0/0", src0_ready, regWrite);
    end
    @(negedge clock);
    reset = 0;
    clearInputs();
  endtask

  task automatic checkOutput_random(input int cyc);
    bit g0, g1;
    bit p0, p1;
    p0 = 0; p1 = 0;
    for (int n = 0; n < cyc; n++) begin
      @(negedge clock);
      if (!p0 && $urandom_range(1, 0) == 1) begin
        p0 = 1; src0_reg = 5'($urandom_range(7, 0)); src0_data = $urandom;
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        p1 = 1; src1_reg = 5'($urandom_range(7, 0)); src1_data = $urandom;
      end
      src0_valid  = p0;
      src1_valid  = p1;
      issue_valid = ($urandom_range(9, 0) < 3);
      issue_reg   = 5'($urandom_range(7, 0));
      query_reg1  = 5'($urandom_range(7, 0));
      query_reg2  = 5'($urandom_range(7, 0));
      #1;
      modelGrant(g0, g1);
      nChecks++;
      if (src0_ready !== g0 || src1_ready !== g1) begin
        nFail++;
        $display("[TB] FAIL rand_ready@%0d: ready=%b%b want %b%b", n, src1_ready, src0_ready, g1, g0);
      end
      nChecks++;
      if (busy1 !== mBusy[query_reg1] || busy2 !== mBusy[query_reg2] ||
          stall !== (mBusy[query_reg1] | mBusy[query_reg2])) begin
        nFail++;
        $display("[TB] FAIL rand_busy@%0d: busy1=%b busy2=%b stall=%b want %b/%b", n,
                 busy1, busy2, stall, mBusy[query_reg1], mBusy[query_reg2]);
      end
      tick();
      if (g0) p0 = 0;
      if (g1) p1 = 0;
      nChecks++;
      if (regWrite !== mRegWrite || writeReg !== mWReg || writeData !== mWData || waw_error !== mWaw) begin
        nFail++;
        $display("[TB] FAIL rand_write@%0d: regWrite=%b writeReg=%0d writeData=%h waw=%b want %b/%0d/%h/%b",
                 n, regWrite, writeReg, writeData, waw_error, mRegWrite, mWReg, mWData, mWaw);
      end
    end
    @(negedge clock);
    clearInputs();
  endtask

  initial begin
    modelReset();
    test_reset();
    test_single_write();
    test_contention();
    test_scoreboard();
    test_reg_zero();
    test_waw();
    test_reset_midop();
    applyStimulus_reset();
    checkOutput_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
